// File: rtl/writeback_stage.sv
// Writeback stage: retires memory loads and immediate loads into the
// register file and forwards every accepted instruction downstream.
// Optional feature macro: WRITEBACK_BYPASS_EN adds a combinational bypass
// port carrying a completing load's data one cycle ahead of the write.
//
// Handshake: a transfer happens on a rising clock edge where inbound_valid
// and inbound_ready are both high; inbound_ready is high only in IDLE and
// does not depend on inbound_valid.
//
// Encodings: opcode NOP=0, LOAD=1, LOADI=2; width BYTE=0, WORD=1, LONG=2
// (3 behaves as LONG); immediate type IT_UNSIGNED=0.
module writeback_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int INDEX_WIDTH    = 4,
    parameter int TIMEOUT_CYCLES = 15,
    localparam int LANE_WIDTH    = $clog2(DATA_WIDTH / 8)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inbound_valid,
    output logic                   inbound_ready,
    input  logic [31:0]            inbound_instruction,
    input  logic [LANE_WIDTH-1:0]  inbound_lane,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_ack,
    output logic                   write,
    output logic [INDEX_WIDTH-1:0] write_index,
    output logic [DATA_WIDTH-1:0]  write_data,
    output logic                   write_immediate,
    output logic [15:0]            write_immediate_data,
    output logic [1:0]             write_immediate_type,
    output logic                   outbound_valid,
    output logic [31:0]            outbound_instruction,
    output logic                   bus_error,
`ifdef WRITEBACK_BYPASS_EN
    output logic                   bypass_valid,
    output logic [INDEX_WIDTH-1:0] bypass_index,
    output logic [DATA_WIDTH-1:0]  bypass_data,
`endif
    output logic [0:0]             debug_state
);
    localparam logic [4:0] OPCODE_NOP   = 5'd0;
    localparam logic [4:0] OPCODE_LOAD  = 5'd1;
    localparam logic [4:0] OPCODE_LOADI = 5'd2;
    localparam logic [1:0] CW_BYTE      = 2'd0;
    localparam logic [1:0] CW_WORD      = 2'd1;
    localparam logic [1:0] IT_UNSIGNED  = 2'd0;
    localparam logic [7:0] LAST_COUNT   = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

    state_t                  state, next_state;
    logic [7:0]              count, next_count;
    logic [LANE_WIDTH-1:0]   lane_q, next_lane;
    logic                    next_write, next_write_immediate, next_bus_error, next_outbound_valid;
    logic [INDEX_WIDTH-1:0]  next_write_index;
    logic [DATA_WIDTH-1:0]   next_write_data;
    logic [15:0]             next_write_immediate_data;
    logic [1:0]              next_write_immediate_type;
    logic [31:0]             next_outbound_instruction;

    // Load attributes come from the inbound bus in IDLE and from the
    // instruction latched at transfer while waiting for memory.
    logic [31:0]             cur_instr;
    logic [LANE_WIDTH-1:0]   cur_lane, lane_eff;
    logic [1:0]              cur_width;
    logic                    cur_sign, misaligned, transfer, load_complete;
    logic [LANE_WIDTH+2:0]   shift;
    logic [DATA_WIDTH-1:0]   shifted, extracted;

    assign inbound_ready = (state == IDLE);
    assign transfer      = inbound_valid && inbound_ready;
    assign cur_instr     = (state == IDLE) ? inbound_instruction : outbound_instruction;
    assign cur_lane      = (state == IDLE) ? inbound_lane : lane_q;
    assign cur_width     = cur_instr[26:25];
    assign cur_sign      = cur_instr[24];
    assign debug_state   = state;
    assign load_complete = data_ack && ((state == WAIT_MEM) ||
                           (transfer && inbound_instruction[31:27] == OPCODE_LOAD));

    // Lane extraction with sign/zero extension and alignment check.
    always_comb begin
        lane_eff = cur_lane;
        if (cur_width == CW_WORD) begin
            lane_eff[0] = 1'b0;
        end else if (cur_width != CW_BYTE) begin
            lane_eff[1:0] = 2'b00;
        end
        shift   = {lane_eff, 3'b000};
        shifted = data_in >> shift;
        if (cur_width == CW_BYTE) begin
            extracted       = {DATA_WIDTH{cur_sign & shifted[7]}};
            extracted[7:0]  = shifted[7:0];
        end else if (cur_width == CW_WORD) begin
            extracted       = {DATA_WIDTH{cur_sign & shifted[15]}};
            extracted[15:0] = shifted[15:0];
        end else begin
            extracted       = {DATA_WIDTH{cur_sign & shifted[31]}};
            extracted[31:0] = shifted[31:0];
        end
        misaligned = ((cur_width == CW_WORD) && cur_lane[0]) ||
                     (cur_width[1] && (cur_lane[1:0] != 2'b00));
    end

`ifdef WRITEBACK_BYPASS_EN
    assign bypass_valid = load_complete && !misaligned;
    assign bypass_index = cur_instr[20 +: INDEX_WIDTH];
    assign bypass_data  = extracted;
`endif

    // Next-state and next-output decode.
    always_comb begin
        next_state                = state;
        next_count                = count;
        next_lane                 = lane_q;
        next_write                = 1'b0;
        next_write_immediate      = 1'b0;
        next_bus_error            = 1'b0;
        next_outbound_valid       = 1'b0;
        next_write_index          = write_index;
        next_write_data           = write_data;
        next_write_immediate_data = write_immediate_data;
        next_write_immediate_type = write_immediate_type;
        next_outbound_instruction = outbound_instruction;
        if (state == IDLE) begin
            if (transfer) begin
                next_outbound_instruction = inbound_instruction;
                next_outbound_valid       = 1'b1;
                next_lane                 = inbound_lane;
                if (inbound_instruction[31:27] == OPCODE_LOADI) begin
                    next_write_immediate      = 1'b1;
                    next_write_index          = inbound_instruction[20 +: INDEX_WIDTH];
                    next_write_immediate_data = inbound_instruction[15:0];
                    next_write_immediate_type = inbound_instruction[26:25];
                end else if (inbound_instruction[31:27] == OPCODE_LOAD && !data_ack) begin
                    next_outbound_valid = 1'b0;
                    next_state          = WAIT_MEM;
                    next_count          = 8'd0;
                end
            end
        end else begin
            if (data_ack) begin
                next_outbound_valid = 1'b1;
                next_state          = IDLE;
            end else if (count == LAST_COUNT) begin
                next_outbound_valid = 1'b1;
                next_bus_error      = 1'b1;
                next_state          = IDLE;
            end else begin
                next_count = count + 8'd1;
            end
        end
        if (load_complete) begin
            if (misaligned) begin
                next_bus_error = 1'b1;
            end else begin
                next_write       = 1'b1;
                next_write_index = cur_instr[20 +: INDEX_WIDTH];
                next_write_data  = extracted;
            end
        end
    end

    // State and registered output update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= IDLE;
            count                <= 8'd0;
            lane_q               <= '0;
            write                <= 1'b0;
            write_immediate      <= 1'b0;
            bus_error            <= 1'b0;
            outbound_valid       <= 1'b0;
            write_index          <= '0;
            write_data           <= '0;
            write_immediate_data <= 16'h0;
            write_immediate_type <= IT_UNSIGNED;
            outbound_instruction <= {OPCODE_NOP, 27'h0};
        end else begin
            state                <= next_state;
            count                <= next_count;
            lane_q               <= next_lane;
            write                <= next_write;
            write_immediate      <= next_write_immediate;
            bus_error            <= next_bus_error;
            outbound_valid       <= next_outbound_valid;
            write_index          <= next_write_index;
            write_data           <= next_write_data;
            write_immediate_data <= next_write_immediate_data;
            write_immediate_type <= next_write_immediate_type;
            outbound_instruction <= next_outbound_instruction;
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a 32-bit instance with a short
// timeout and a 64-bit instance for wide-lane extraction.
module tb_writeback_stage;
    localparam logic [4:0] OP_NOP = 5'd0, OP_LOAD = 5'd1, OP_LOADI = 5'd2, OP_ALU = 5'd5;
    localparam logic [1:0] CW_BYTE = 2'd0, CW_WORD = 2'd1, CW_LONG = 2'd2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    // 32-bit instance signals
    logic        a_valid = 0, a_ack = 0, a_ready, a_write, a_wimm, a_ov, a_berr;
    logic [31:0] a_instr = 0, a_data = 0, a_wdata, a_oi;
    logic [1:0]  a_lane = 0, a_wit;
    logic [3:0]  a_widx;
    logic [15:0] a_wid;
    logic [0:0]  a_state;

    // 64-bit instance signals
    logic        b_valid = 0, b_ack = 0, b_ready, b_write, b_wimm, b_ov, b_berr;
    logic [31:0] b_instr = 0, b_oi;
    logic [63:0] b_data = 0, b_wdata;
    logic [2:0]  b_lane = 0;
    logic [1:0]  b_wit;
    logic [3:0]  b_widx;
    logic [15:0] b_wid;
    logic [0:0]  b_state;

`ifdef WRITEBACK_BYPASS_EN
    logic        a_bv, b_bv;
    logic [3:0]  a_bi, b_bi;
    logic [31:0] a_bd;
    logic [63:0] b_bd;
`endif

    writeback_stage #(.DATA_WIDTH(32), .INDEX_WIDTH(4), .TIMEOUT_CYCLES(4)) dut_a (
        .clock(clock), .reset(reset), .inbound_valid(a_valid), .inbound_ready(a_ready),
        .inbound_instruction(a_instr), .inbound_lane(a_lane), .data_in(a_data), .data_ack(a_ack),
        .write(a_write), .write_index(a_widx), .write_data(a_wdata),
        .write_immediate(a_wimm), .write_immediate_data(a_wid), .write_immediate_type(a_wit),
        .outbound_valid(a_ov), .outbound_instruction(a_oi), .bus_error(a_berr),
`ifdef WRITEBACK_BYPASS_EN
        .bypass_valid(a_bv), .bypass_index(a_bi), .bypass_data(a_bd),
`endif
        .debug_state(a_state));

    writeback_stage #(.DATA_WIDTH(64), .INDEX_WIDTH(4)) dut_b (
        .clock(clock), .reset(reset), .inbound_valid(b_valid), .inbound_ready(b_ready),
        .inbound_instruction(b_instr), .inbound_lane(b_lane), .data_in(b_data), .data_ack(b_ack),
        .write(b_write), .write_index(b_widx), .write_data(b_wdata),
        .write_immediate(b_wimm), .write_immediate_data(b_wid), .write_immediate_type(b_wit),
        .outbound_valid(b_ov), .outbound_instruction(b_oi), .bus_error(b_berr),
`ifdef WRITEBACK_BYPASS_EN
        .bypass_valid(b_bv), .bypass_index(b_bi), .bypass_data(b_bd),
`endif
        .debug_state(b_state));

    // Clock generation
    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [1:0] w,
                                       input logic s, input logic [3:0] idx, input logic [15:0] imm);
        mk = {op, w, s, idx, 4'h0, imm};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] instr_keep;

    initial begin
        step();
        step();
        check("rst_write", a_write, 0);
        check("rst_wimm", a_wimm, 0);
        check("rst_berr", a_berr, 0);
        check("rst_ov", a_ov, 0);
        check("rst_oi", a_oi, {OP_NOP, 27'h0});
        check("rst_wit", a_wit, 0);
        check("rst_wdata", a_wdata, 0);
        check("rst_widx", a_widx, 0);
        check("rst_wid", a_wid, 0);
        check("rst_ready", a_ready, 1);
        check("rst_state", a_state, 0);
        reset = 1'b0;

        // Signed byte load, data present in the transfer cycle
        instr_keep = mk(OP_LOAD, CW_BYTE, 1'b1, 4'd3, 16'h0);
        a_valid = 1; a_instr = instr_keep; a_lane = 2; a_data = 32'h0080_0000; a_ack = 1;
        step();
        a_valid = 0; a_ack = 0;
        check("byte_write", a_write, 1);
        check("byte_data", a_wdata, 32'hFFFF_FF80);
        check("byte_idx", a_widx, 3);
        check("byte_ov", a_ov, 1);
        check("byte_oi", a_oi, instr_keep);
        check("byte_berr", a_berr, 0);
        step();
        check("byte_write_pulse", a_write, 0);
        check("byte_ov_drop", a_ov, 0);
        check("byte_oi_hold", a_oi, instr_keep);

        // Immediate load
        a_valid = 1; a_instr = mk(OP_LOADI, 2'd1, 1'b0, 4'd5, 16'h1234);
        step();
        a_valid = 0;
        check("loadi_wimm", a_wimm, 1);
        check("loadi_idx", a_widx, 5);
        check("loadi_data", a_wid, 16'h1234);
        check("loadi_type", a_wit, 1);
        check("loadi_write", a_write, 0);
        step();
        check("loadi_pulse", a_wimm, 0);

        // Stray data_ack in IDLE is ignored
        a_ack = 1; a_data = 32'hDEAD_BEEF;
        step();
        a_ack = 0;
        check("stray_ack_write", a_write, 0);

        // Unsigned word load completing after three wait cycles
        a_valid = 1; a_instr = mk(OP_LOAD, CW_WORD, 1'b0, 4'd7, 16'h0); a_lane = 2;
        check("word_ready_pre", a_ready, 1);
        step();
        a_valid = 0; a_lane = 1;
        for (int i = 0; i < 3; i++) begin
            check("word_wait_ready", a_ready, 0);
            check("word_wait_ov", a_ov, 0);
            if (i == 2) begin
                a_ack = 1; a_data = 32'hBEEF_0000;
            end
            step();
        end
        a_ack = 0;
        check("word_write", a_write, 1);
        check("word_data", a_wdata, 32'h0000_BEEF);
        check("word_idx", a_widx, 7);
        check("word_ov", a_ov, 1);
        check("word_ready_post", a_ready, 1);

        // Timeout after four wait cycles
        a_valid = 1; a_instr = mk(OP_LOAD, CW_BYTE, 1'b0, 4'd2, 16'h0); a_lane = 0;
        step();
        a_valid = 0;
        for (int i = 0; i < 4; i++) begin
            check("to_wait_ready", a_ready, 0);
            check("to_wait_berr", a_berr, 0);
            step();
        end
        check("to_berr", a_berr, 1);
        check("to_write", a_write, 0);
        check("to_ov", a_ov, 1);
        check("to_ready", a_ready, 1);
        step();
        check("to_berr_pulse", a_berr, 0);

        // Misaligned long load with data in the transfer cycle
        a_valid = 1; a_instr = mk(OP_LOAD, CW_LONG, 1'b0, 4'd4, 16'h0); a_lane = 1; a_ack = 1;
        step();
        a_valid = 0; a_ack = 0;
        check("mis_long_berr", a_berr, 1);
        check("mis_long_write", a_write, 0);
        check("mis_long_ov", a_ov, 1);

        // Misaligned word load completing from WAIT_MEM
        a_valid = 1; a_instr = mk(OP_LOAD, CW_WORD, 1'b0, 4'd4, 16'h0); a_lane = 3;
        step();
        a_valid = 0; a_lane = 0; a_ack = 1;
        step();
        a_ack = 0;
        check("mis_word_berr", a_berr, 1);
        check("mis_word_write", a_write, 0);
        step();
        check("mis_word_berr_pulse", a_berr, 0);

        // Other opcode passes through
        instr_keep = mk(OP_ALU, 2'd0, 1'b0, 4'd9, 16'hABCD);
        a_valid = 1; a_instr = instr_keep;
        step();
        a_valid = 0;
        check("alu_ov", a_ov, 1);
        check("alu_oi", a_oi, instr_keep);
        check("alu_write", a_write, 0);
        check("alu_wimm", a_wimm, 0);

        // Reset during WAIT_MEM abandons the load
        a_valid = 1; a_instr = mk(OP_LOAD, CW_BYTE, 1'b0, 4'd6, 16'h0); a_lane = 0;
        step();
        a_valid = 0;
        check("rw_state", a_state, 1);
        reset = 1;
        step();
        reset = 0; a_ack = 1; a_data = 32'h0000_00FF;
        step();
        a_ack = 0;
        check("rw_write", a_write, 0);
        check("rw_berr", a_berr, 0);
        check("rw_oi", a_oi, {OP_NOP, 27'h0});
        check("rw_ov", a_ov, 0);
        check("rw_ready", a_ready, 1);

        // 64-bit: long load from upper half
        b_valid = 1; b_instr = mk(OP_LOAD, CW_LONG, 1'b0, 4'd1, 16'h0); b_lane = 4;
        b_data = 64'h1122_3344_5566_7788; b_ack = 1;
        step();
        b_valid = 0; b_ack = 0;
        check("w64_long_write", b_write, 1);
        check("w64_long_data", b_wdata, 64'h0000_0000_1122_3344);

        // 64-bit: misaligned word
        b_valid = 1; b_instr = mk(OP_LOAD, CW_WORD, 1'b0, 4'd2, 16'h0); b_lane = 1; b_ack = 1;
        step();
        b_valid = 0; b_ack = 0;
        check("w64_mis_berr", b_berr, 1);
        check("w64_mis_write", b_write, 0);

        // 64-bit: signed top byte
        b_valid = 1; b_instr = mk(OP_LOAD, CW_BYTE, 1'b1, 4'd3, 16'h0); b_lane = 7;
        b_data = 64'h8000_0000_0000_0000; b_ack = 1;
        step();
        b_valid = 0; b_ack = 0;
        check("w64_byte_write", b_write, 1);
        check("w64_byte_data", b_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        check("w64_byte_idx", b_widx, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
